// File: rtl/result_arbiter.sv
// Round-robin result collector: grants one pending neuron result per cycle into a
// show-ahead FIFO that drains to the framebuffer, and counts transfers toward frame completion.
module result_arbiter #(
    parameter int N_NEURONS  = 36,
    parameter int ITER_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [15:0]                   pix_target,
    input  logic [N_NEURONS-1:0]          result_valid,
    input  logic [N_NEURONS*16-1:0]       result_pixel_id,
    input  logic [N_NEURONS*ITER_W-1:0]   result_iter,
    output logic [N_NEURONS-1:0]          result_ack,
    output logic                          fb_wr_en,
    output logic [15:0]                   fb_wr_addr,
    output logic [ITER_W-1:0]             fb_wr_data,
    input  logic                          fb_wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pixels_done,
    output logic                          frame_done
);

    localparam int PTR_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [N_NEURONS-1:0] ack_q, ack_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [15:0]          pix_q, pix_d;
    logic                 done_q, done_d;
    logic                 fired_q, fired_d;

    logic [15:0]          mem_id_q   [FIFO_DEPTH];
    logic [ITER_W-1:0]    mem_iter_q [FIFO_DEPTH];

    logic [N_NEURONS-1:0] eligible;
    logic                 grant_found;
    logic                 grant;
    logic                 pop;
    logic [PTR_W-1:0]     grant_idx;
    logic [15:0]          grant_id;
    logic [ITER_W-1:0]    grant_iter;
    int                   cand;

    // Search upward from rr_q+1, wrapping at N_NEURONS; an acked neuron is masked
    // for the ack cycle so the same result cannot be taken twice.
    always_comb begin
        eligible    = result_valid & ~ack_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= N_NEURONS; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= N_NEURONS) cand = cand - N_NEURONS;
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
        grant      = grant_found && (level_q < LVL_W'(FIFO_DEPTH)) && !clear;
        grant_id   = result_pixel_id[int'(grant_idx)*16 +: 16];
        grant_iter = result_iter[int'(grant_idx)*ITER_W +: ITER_W];
        pop        = (level_q != '0) && fb_wr_ready;
    end

    always_comb begin
        rr_d    = rr_q;
        ack_d   = '0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        pix_d   = pix_q;
        done_d  = 1'b0;
        fired_d = fired_q;
        if (clear) begin
            rr_d    = PTR_W'(N_NEURONS - 1);
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            pix_d   = '0;
            fired_d = 1'b0;
        end else begin
            if (grant) begin
                rr_d            = grant_idx;
                ack_d[grant_idx] = 1'b1;
                wr_d            = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d  = rd_q + AW'(1);
                pix_d = pix_q + 16'd1;
                if ((pix_q + 16'd1 == pix_target) && (pix_target != 16'd0) && !fired_q) begin
                    done_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end
            case ({grant, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= PTR_W'(N_NEURONS - 1);
            ack_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            fired_q <= fired_d;
        end
    end

    // Storage needs no reset: the head is only exposed while level_q is non-zero.
    always_ff @(posedge clk) begin
        if (grant) begin
            mem_id_q[wr_q]   <= grant_id;
            mem_iter_q[wr_q] <= grant_iter;
        end
    end

    assign result_ack  = ack_q;
    assign fb_wr_en    = (level_q != '0);
    assign fb_wr_addr  = fb_wr_en ? mem_id_q[rd_q] : 16'd0;
    assign fb_wr_data  = fb_wr_en ? mem_iter_q[rd_q] : '0;
    assign fifo_level  = level_q;
    assign pixels_done = pix_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_result_arbiter.sv
// Bench for result_arbiter: directed table and sequences plus randomized traffic,
// all checked against a queue-based reference model of the arbiter and buffer.
module tb_result_arbiter;

    localparam int N     = 36;
    localparam int IW    = 16;
    localparam int DEPTH = 8;

    logic                clk;
    logic                rst_n;
    logic                clear;
    logic [15:0]         pix_target;
    logic [N-1:0]        result_valid;
    logic [N*16-1:0]     result_pixel_id;
    logic [N*IW-1:0]     result_iter;
    logic [N-1:0]        result_ack;
    logic                fb_wr_en;
    logic [15:0]         fb_wr_addr;
    logic [IW-1:0]       fb_wr_data;
    logic                fb_wr_ready;
    logic [3:0]          fifo_level;
    logic [15:0]         pixels_done;
    logic                frame_done;

    result_arbiter #(.N_NEURONS(N), .ITER_W(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pix_target(pix_target),
        .result_valid(result_valid), .result_pixel_id(result_pixel_id),
        .result_iter(result_iter), .result_ack(result_ack),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .fb_wr_ready(fb_wr_ready), .fifo_level(fifo_level),
        .pixels_done(pixels_done), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] q_id[$];
    logic [15:0] q_it[$];
    int  m_rr;
    int  m_ack;
    int  m_pix;
    bit  m_fired;
    bit  m_fd;

    int  mode;      // 0 none, 1 drop valid on ack, 2 hold valid, 3 random
    int  obs_ack;
    int  fd_cnt;
    int  fd_pix;

    typedef struct {
        int          n;
        logic [15:0] id;
        logic [15:0] it;
        logic [N-1:0] exp_ack;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_id.delete();
        q_it.delete();
        m_rr = N - 1; m_ack = -1; m_pix = 0; m_fired = 0; m_fd = 0;
    endtask

    task automatic set_req(input int n, input logic [15:0] id, input logic [15:0] it);
        result_valid[n] = 1'b1;
        result_pixel_id[n*16 +: 16] = id;
        result_iter[n*IW +: IW] = it;
    endtask

    task automatic check_all();
        logic [N-1:0] e;
        e = '0;
        if (m_ack >= 0) e[m_ack] = 1'b1;
        chk("ack", 64'(result_ack), 64'(e));
        chk("wr_en", 64'(fb_wr_en), 64'(q_id.size() > 0));
        chk("level", 64'(fifo_level), 64'(q_id.size()));
        chk("pixels_done", 64'(pixels_done), 64'(m_pix));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        if (q_id.size() > 0) begin
            chk("wr_addr", 64'(fb_wr_addr), 64'(q_id[0]));
            chk("wr_data", 64'(fb_wr_data), 64'(q_it[0]));
        end
    endtask

    task automatic respond();
        if (mode == 1 && m_ack >= 0) result_valid[m_ack] = 1'b0;
        if (mode == 3) begin
            for (int n = 0; n < N; n++) begin
                if (m_ack == n) begin
                    if ($urandom_range(1, 0) == 1) set_req(n, 16'($urandom), 16'($urandom));
                    else result_valid[n] = 1'b0;
                end else if (!result_valid[n]) begin
                    if ($urandom_range(3, 0) == 0) set_req(n, 16'($urandom), 16'($urandom));
                    else begin
                        result_pixel_id[n*16 +: 16] = 16'($urandom);
                        result_iter[n*IW +: IW] = 16'($urandom);
                    end
                end
            end
            fb_wr_ready = ($urandom_range(3, 0) != 0);
            clear = ($urandom_range(39, 0) == 0);
        end
    endtask

    // One clock: predict from the inputs seen before the edge, then compare after it.
    task automatic tick();
        int g;
        bit pop;
        logic [15:0] gid, git;
        g = -1; gid = '0; git = '0;
        if (!clear && q_id.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (result_valid[c] && c != m_ack) begin
                    g = c;
                    break;
                end
            end
        end
        if (g >= 0) begin
            gid = result_pixel_id[g*16 +: 16];
            git = result_iter[g*IW +: IW];
        end
        pop = !clear && q_id.size() > 0 && fb_wr_ready;
        @(posedge clk);
        #1;
        if (clear) begin
            model_reset();
        end else begin
            m_fd = 0;
            if (pop) begin
                void'(q_id.pop_front());
                void'(q_it.pop_front());
                m_pix = (m_pix + 1) % 65536;
                if (m_pix == int'(pix_target) && pix_target != 0 && !m_fired) begin
                    m_fd = 1;
                    m_fired = 1;
                end
            end
            if (g >= 0) begin
                q_id.push_back(gid);
                q_it.push_back(git);
                m_rr = g;
            end
            m_ack = g;
        end
        check_all();
        obs_ack = -1;
        for (int n = 0; n < N; n++) if (result_ack[n]) obs_ack = n;
        if (frame_done) begin
            fd_cnt++;
            fd_pix = int'(pixels_done);
        end
        respond();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain();
        result_valid = '0;
        fb_wr_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && (q_id.size() > 0 || m_ack >= 0); i++) tick();
        chk("drained", 64'(fifo_level), 64'd0);
    endtask

    int exp_order[6] = '{0, 1, 35, 0, 1, 35};
    int ack_cnt;
    int pix_before;

    initial begin
        vecs[0] = '{5,  16'h0100, 16'd42,   36'h0_0000_0020};
        vecs[1] = '{0,  16'hFFFF, 16'd0,    36'h0_0000_0001};
        vecs[2] = '{35, 16'h1234, 16'hFFFF, 36'h8_0000_0000};
        vecs[3] = '{17, 16'h0000, 16'd7,    36'h0_0002_0000};
        vecs[4] = '{18, 16'hABCD, 16'h8000, 36'h0_0004_0000};

        rst_n = 1'b0; clear = 1'b0; pix_target = 16'd0; result_valid = '0;
        result_pixel_id = '0; result_iter = '0; fb_wr_ready = 1'b1; mode = 0;
        fd_cnt = 0; fd_pix = 0; obs_ack = -1;
        model_reset();
        #22 rst_n = 1'b1;
        check_all();

        // single-request table
        mode = 1;
        for (int v = 0; v < 5; v++) begin
            pix_before = m_pix;
            set_req(vecs[v].n, vecs[v].id, vecs[v].it);
            tick();
            chk("tbl_ack", 64'(result_ack), 64'(vecs[v].exp_ack));
            chk("tbl_en", 64'(fb_wr_en), 64'd1);
            chk("tbl_addr", 64'(fb_wr_addr), 64'(vecs[v].id));
            chk("tbl_data", 64'(fb_wr_data), 64'(vecs[v].it));
            tick();
            chk("tbl_pix", 64'(pixels_done), 64'(pix_before + 1));
        end

        // fairness among 0, 1, 35 holding valid
        do_clear();
        mode = 2;
        set_req(0, 16'h0A00, 16'd1);
        set_req(1, 16'h0A01, 16'd2);
        set_req(35, 16'h0A23, 16'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fair_order", 64'(obs_ack), 64'(exp_order[i]));
        end
        drain();

        // backpressure to full, then in-order drain
        do_clear();
        mode = 1;
        fb_wr_ready = 1'b0;
        for (int n = 0; n < N; n++) set_req(n, 16'h1000 + 16'(n), 16'h2000 + 16'(n));
        ack_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_ack >= 0) ack_cnt++;
            chk("bp_stable_addr", 64'(fb_wr_addr), 64'h1000);
            chk("bp_stable_data", 64'(fb_wr_data), 64'h2000);
        end
        chk("bp_ack_count", 64'(ack_cnt), 64'd8);
        chk("bp_level", 64'(fifo_level), 64'd8);
        fb_wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_order", 64'(fb_wr_addr), 64'h1000 + 64'(i));
            tick();
        end
        drain();

        // clear with 4 buffered and a grant pending
        mode = 1;
        fb_wr_ready = 1'b0;
        for (int n = 10; n < 14; n++) set_req(n, 16'h3000 + 16'(n), 16'd9);
        for (int i = 0; i < 4; i++) tick();
        chk("clr_pre_level", 64'(fifo_level), 64'd4);
        set_req(2, 16'h3002, 16'd5);
        set_req(20, 16'h3014, 16'd6);
        do_clear();
        chk("clr_level", 64'(fifo_level), 64'd0);
        chk("clr_pix", 64'(pixels_done), 64'd0);
        chk("clr_ack", 64'(result_ack), 64'd0);
        tick();
        chk("clr_first_grant", 64'(obs_ack), 64'd2);
        drain();

        // completion at pix_target = 3, fourth transfer silent
        pix_target = 16'd3;
        do_clear();
        mode = 1;
        fd_cnt = 0;
        fd_pix = 0;
        for (int r = 0; r < 4; r++) begin
            set_req(20 + r, 16'h4000 + 16'(r), 16'(r));
            for (int i = 0; i < 3; i++) tick();
        end
        chk("done_count", 64'(fd_cnt), 64'd1);
        chk("done_at_pix", 64'(fd_pix), 64'd3);
        drain();

        // asynchronous reset with 5 buffered
        mode = 1;
        fb_wr_ready = 1'b0;
        for (int n = 0; n < 5; n++) set_req(n, 16'h5000 + 16'(n), 16'd11);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_pre_level", 64'(fifo_level), 64'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ack", 64'(result_ack), 64'd0);
        chk("rst_en", 64'(fb_wr_en), 64'd0);
        chk("rst_addr", 64'(fb_wr_addr), 64'd0);
        chk("rst_data", 64'(fb_wr_data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_pix", 64'(pixels_done), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        model_reset();
        result_valid = '0;
        fb_wr_ready = 1'b1;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_write", 64'(fb_wr_en), 64'd0);
        end
        set_req(9, 16'h5109, 16'd77);
        tick();
        chk("rst_fresh_addr", 64'(fb_wr_addr), 64'h5109);
        drain();

        // randomized traffic
        pix_target = 16'd12;
        do_clear();
        mode = 3;
        for (int i = 0; i < 3000; i++) tick();
        mode = 0;
        clear = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_arbiter.md
RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 Parameter N_NEURONS, default 36: number of result requesters.
REQ-002 Parameter ITER_W, default 16: iteration-count width.
REQ-003 Parameter FIFO_DEPTH, default 8: result buffer entries, power of two, at least 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have the remaining ports below.
- clear  in  1  synchronous flush, pulsed at frame start.
- pix_target  in  16  result transfers per frame.
- result_valid  in  N_NEURONS  per-neuron result pending; held until acked.
- result_pixel_id  in  N_NEURONS*16  flat, neuron i at [i*16 +: 16].
- result_iter  in  N_NEURONS*ITER_W  flat, neuron i at [i*ITER_W +: ITER_W].
- result_ack  out  N_NEURONS  one-hot accept pulse.
- fb_wr_en  out  1  framebuffer write request.
- fb_wr_addr  out  16  write address (pixel id).
- fb_wr_data  out  ITER_W  iteration count.
- fb_wr_ready  in  1  framebuffer accepts the write this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
- pixels_done  out  16  transfers completed since clear.
- frame_done  out  1  one-cycle completion pulse.

Function
REQ-006 Eligible set: result_valid AND NOT result_ack, so a neuron is never granted twice for one result.
REQ-007 Grant condition: a grant SHALL occur in cycle t when the eligible set is non-empty, fifo_level < FIFO_DEPTH and clear is low.
REQ-008 Grant selection: round-robin, searching upward from rr_ptr+1 modulo N_NEURONS and taking the first eligible neuron.
REQ-009 On grant of neuron g in cycle t:
- pixel id and iter of neuron g SHALL be written into the FIFO at the end of cycle t.
- rr_ptr SHALL be set to g.
- result_ack[g] SHALL be high in cycle t+1 only.
REQ-010 At most one grant SHALL occur per cycle, and at most one result_ack bit SHALL be high.
REQ-011 FIFO output is show-ahead:
- fb_wr_en equals "FIFO not empty".
- fb_wr_addr and fb_wr_data SHALL present the head entry.
- A transfer occurs when fb_wr_en and fb_wr_ready are both high, popping the head at that edge.
REQ-012 While fb_wr_en is high and fb_wr_ready is low, fb_wr_addr and fb_wr_data SHALL hold stable.
REQ-013 A simultaneous push and pop SHALL leave fifo_level unchanged and keep entries in order.
- A push into an empty FIFO becomes visible on fb_wr_* in cycle t+1.
- Push-to-output latency is 1 cycle.
REQ-014 Full boundary: at fifo_level == FIFO_DEPTH, no grant SHALL occur, even if a pop happens in the same cycle.
REQ-015 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 pixels_done SHALL increment by 1 per transfer and wrap at 16 bits.
REQ-017 frame_done SHALL pulse for one cycle in the cycle after the transfer that makes pixels_done equal pix_target.
- It SHALL never fire for pix_target == 0.
- It SHALL not re-fire until after a clear.
REQ-018 When clear is high, at the next edge the block SHALL:
- empty the FIFO;
- zero pixels_done;
- set rr_ptr to N_NEURONS-1, so neuron 0 has first priority;
- zero result_ack;
- suppress frame_done.
REQ-019 clear SHALL take priority over any simultaneous grant, push, pop or done event.
- Granted-but-unacked results are dropped.
- The owning neurons keep result_valid high and are re-granted after clear.
REQ-020 Invalid input data on non-granted neurons SHALL have no effect.

Reset
REQ-021 When rst_n is low, the following SHALL take effect asynchronously:
- result_ack = 0, fb_wr_en = 0, fb_wr_addr = 0, fb_wr_data = 0;
- fifo_level = 0, pixels_done = 0, frame_done = 0;
- rr_ptr = N_NEURONS-1, done-fired flag = 0.
REQ-022 Reset asserted mid-operation SHALL discard all buffered results; no fb_wr_en SHALL occur until a new grant after rst_n deasserts.

Verification
REQ-023 Single request: result_valid[5] = 1 with id 0x0100, iter 42, fb_wr_ready = 1.
- result_ack[5] pulses in cycle t+1.
- fb_wr_en = 1 in cycle t+1 with addr 0x0100, data 42.
- pixels_done = 1 afterwards.
REQ-024 Fairness: neurons 0, 1 and 35 held valid, with each neuron re-asserting valid after its ack. Grant order SHALL be 0, 1, 35, 0, 1, 35, and no ack SHALL repeat on consecutive cycles.
REQ-025 Backpressure and full:
- fb_wr_ready = 0 with all 36 neurons valid: exactly 8 acks occur, fifo_level = 8, fb_wr_* stable.
- After fb_wr_ready = 1: 8 in-order transfers with no loss or duplication.
REQ-026 Completion: pix_target = 3 with three results transferred. frame_done SHALL pulse exactly once, one cycle after the third transfer; a fourth transfer produces no pulse.
REQ-027 Clear with 4 entries buffered and a grant in progress:
- The FIFO empties and pixels_done = 0.
- The next grant goes to the lowest-index valid neuron.
REQ-028 Reset asserted with 5 entries buffered: all outputs take their reset values immediately, and no write appears after release until a fresh grant.
